// File: rtl/rtc_bus_arbiter.sv
// rtl/rtc_bus_arbiter.sv - three-way arbiter for the shared RTC bus transaction engine
// Timeout guards against a hung engine; aging promotes the periodic reader (2) when starved.
module rtc_bus_arbiter #(
  parameter logic [15:0] TIMEOUT  = 16'd2000,
  parameter logic [7:0]  MAX_WAIT = 8'd64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req_i,
  input  logic [2:0]  we_i,
  input  logic [23:0] addr_i,
  input  logic [23:0] wdata_i,
  output logic [2:0]  gnt_o,
  output logic [2:0]  done_o,
  output logic [7:0]  rdata_o,
  output logic        err_o,
  output logic        busy_o,
  output logic        bus_start,
  output logic        bus_we,
  output logic [7:0]  bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic        bus_fin,
  input  logic [7:0]  bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RELEASE} state_e;

  state_e      state_q;
  logic [2:0]  owner_q;
  logic        we_q;
  logic [7:0]  addr_q;
  logic [7:0]  wdata_q;
  logic [15:0] tcnt_q;
  logic [7:0]  age2_q;

  logic [2:0]  win_oh_d;
  logic        win_we_d;
  logic [7:0]  win_addr_d;
  logic [7:0]  win_wdata_d;

  // Aged requester 2 beats everyone; otherwise lowest index wins.
  always_comb begin
    win_oh_d = 3'b100;
    if (req_i[2] && (age2_q >= MAX_WAIT)) win_oh_d = 3'b100;
    else if (req_i[0])                    win_oh_d = 3'b001;
    else if (req_i[1])                    win_oh_d = 3'b010;
    win_we_d    = |(we_i & win_oh_d);
    win_addr_d  = ({8{win_oh_d[0]}} & addr_i[7:0])   |
                  ({8{win_oh_d[1]}} & addr_i[15:8])  |
                  ({8{win_oh_d[2]}} & addr_i[23:16]);
    win_wdata_d = ({8{win_oh_d[0]}} & wdata_i[7:0])  |
                  ({8{win_oh_d[1]}} & wdata_i[15:8]) |
                  ({8{win_oh_d[2]}} & wdata_i[23:16]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      owner_q   <= 3'b000;
      we_q      <= 1'b0;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      tcnt_q    <= 16'd0;
      age2_q    <= 8'd0;
      gnt_o     <= 3'b000;
      done_o    <= 3'b000;
      rdata_o   <= 8'h00;
      err_o     <= 1'b0;
      busy_o    <= 1'b0;
      bus_start <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 8'h00;
      bus_wdata <= 8'h00;
    end else begin
      if (!req_i[2] || gnt_o[2])  age2_q <= 8'd0;
      else if (age2_q != 8'hFF)   age2_q <= age2_q + 8'd1;

      case (state_q)
        S_IDLE: begin
          if (|req_i) begin
            owner_q <= win_oh_d;
            gnt_o   <= win_oh_d;
            we_q    <= win_we_d;
            addr_q  <= win_addr_d;
            wdata_q <= win_wdata_d;
            busy_o  <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          bus_start <= 1'b1;
          bus_we    <= we_q;
          bus_addr  <= addr_q;
          bus_wdata <= wdata_q;
          tcnt_q    <= 16'd0;
          state_q   <= S_WAIT;
        end
        S_WAIT: begin
          bus_start <= 1'b0;
          if (bus_fin || (tcnt_q == TIMEOUT - 16'd1)) begin
            // A fin landing on the terminal count still wins over the timeout.
            if (bus_fin) begin
              if (!we_q) rdata_o <= bus_rdata;
            end else begin
              err_o   <= 1'b1;
              rdata_o <= 8'hFF;
            end
            done_o    <= owner_q;
            gnt_o     <= 3'b000;
            bus_we    <= 1'b0;
            bus_addr  <= 8'h00;
            bus_wdata <= 8'h00;
            state_q   <= S_RELEASE;
          end else begin
            tcnt_q <= tcnt_q + 16'd1;
          end
        end
        S_RELEASE: begin
          done_o  <= 3'b000;
          err_o   <= 1'b0;
          busy_o  <= 1'b0;
          owner_q <= 3'b000;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// tb/tb_rtc_bus_arbiter.sv - directed bench for rtc_bus_arbiter with a transaction-phase reference model
module tb_rtc_bus_arbiter;

  localparam int TIMEOUT  = 2000;
  localparam int MAX_WAIT = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req_i = 3'b000;
  logic [2:0]  we_i = 3'b000;
  logic [23:0] addr_i = 24'h0;
  logic [23:0] wdata_i = 24'h0;
  logic [2:0]  gnt_o, done_o;
  logic [7:0]  rdata_o;
  logic        err_o, busy_o;
  logic        bus_start, bus_we;
  logic [7:0]  bus_addr, bus_wdata;
  logic        bus_fin = 1'b0;
  logic [7:0]  bus_rdata = 8'h00;

  always #5 clk = ~clk;

  rtc_bus_arbiter #(.TIMEOUT(16'd2000), .MAX_WAIT(8'd64)) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o), .busy_o(busy_o),
    .bus_start(bus_start), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_fin(bus_fin), .bus_rdata(bus_rdata)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Command mailboxes: main writes tail, requester process writes head.
  bit         c_we[3][64];
  logic [7:0] c_addr[3][64];
  logic [7:0] c_wdata[3][64];
  bit         c_hold[3][64];
  int         tail[3] = '{0, 0, 0};
  int         head[3] = '{0, 0, 0};
  int         raise_cyc[3] = '{0, 0, 0};

  int         eng_delay = 5;
  logic [7:0] eng_rdata = 8'h00;
  int         spur_req = 0;

  task automatic push(input int n, input bit we, input logic [7:0] a, input logic [7:0] d, input bit hold);
    c_we[n][tail[n]] = we;
    c_addr[n][tail[n]] = a;
    c_wdata[n][tail[n]] = d;
    c_hold[n][tail[n]] = hold;
    tail[n] = tail[n] + 1;
  endtask

  // Requesters: raise when a command is queued, drop in the done cycle (or one cycle late when asked).
  initial begin
    bit active[3];
    bit hold_cur[3];
    int extra[3];
    for (int n = 0; n < 3; n++) begin active[n] = 0; hold_cur[n] = 0; extra[n] = 0; end
    forever begin
      @(posedge clk); #2;
      for (int n = 0; n < 3; n++) begin
        if (reset) begin
          active[n] = 0; extra[n] = 0; head[n] = tail[n]; req_i[n] = 1'b0;
        end else if (extra[n] > 0) begin
          extra[n]--;
          if (extra[n] == 0) req_i[n] = 1'b0;
        end else if (active[n]) begin
          if (done_o[n]) begin
            active[n] = 0;
            if (hold_cur[n]) extra[n] = 2;
            else req_i[n] = 1'b0;
          end
        end else if (head[n] != tail[n]) begin
          we_i[n] = c_we[n][head[n]];
          addr_i[8*n +: 8] = c_addr[n][head[n]];
          wdata_i[8*n +: 8] = c_wdata[n][head[n]];
          hold_cur[n] = c_hold[n][head[n]];
          head[n] = head[n] + 1;
          req_i[n] = 1'b1;
          active[n] = 1;
          raise_cyc[n] = cyc;
        end
      end
    end
  end

  // Engine: fin eng_delay cycles after bus_start (never when eng_delay is 0), plus on-demand spurious fins.
  initial begin
    int cnt;
    int spur_seen;
    cnt = 0; spur_seen = 0;
    forever begin
      @(posedge clk); #2;
      bus_fin = 1'b0; bus_rdata = 8'h00;
      if (reset) cnt = 0;
      else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin bus_fin = 1'b1; bus_rdata = eng_rdata; end
        end
        if (bus_start && eng_delay > 0) cnt = eng_delay;
        if (spur_req != spur_seen) begin spur_seen = spur_req; bus_fin = 1'b1; bus_rdata = 8'h5A; end
      end
    end
  end

  // Event logs for the literal checks.
  int         st_cyc[$];
  logic [7:0] st_addr[$];
  logic [7:0] st_wdata[$];
  int         dn_cyc[$];
  logic [2:0] dn_val[$];
  logic [7:0] dn_rdata[$];
  bit         dn_err[$];
  int         gr_cyc[$];
  logic [2:0] gr_val[$];

  // Reference model: one transaction at a time, tracked by phase since grant (1 = grant cycle,
  // 2 = start cycle, m_end = done cycle, then one idle cycle before arbitration resumes).
  int         m_owner = -1;
  int         m_ph = 0;
  int         m_end = 0;
  bit         m_err = 0;
  bit         m_we = 0;
  logic [7:0] m_addr = 8'h00, m_wdata = 8'h00, m_rdata = 8'h00;
  int         m_age = 0;
  logic [2:0] e_gnt = 3'b000;

  initial begin
    logic [2:0]  s_req, s_we, e_done, prev_gnt;
    logic [23:0] s_addr, s_wdata;
    logic        s_fin, s_reset, act;
    logic [7:0]  s_rdata;
    logic [33:0] exp_v, act_v;
    int          old_age;
    prev_gnt = 3'b000;
    forever begin
      @(posedge clk);
      s_reset = reset; s_req = req_i; s_we = we_i; s_addr = addr_i; s_wdata = wdata_i;
      s_fin = bus_fin; s_rdata = bus_rdata;
      cyc++;
      if (s_reset) begin
        m_owner = -1; m_ph = 0; m_end = 0; m_err = 0; m_age = 0; m_rdata = 8'h00;
      end else begin
        old_age = m_age;
        if (!s_req[2] || e_gnt[2]) m_age = 0;
        else if (m_age < 255) m_age++;
        if (m_owner < 0) begin
          if (s_req != 3'b000) begin
            if (s_req[2] && old_age >= MAX_WAIT) m_owner = 2;
            else if (s_req[0]) m_owner = 0;
            else if (s_req[1]) m_owner = 1;
            else m_owner = 2;
            m_ph = 1; m_end = 0; m_err = 0;
            m_we = s_we[m_owner];
            m_addr = s_addr[8*m_owner +: 8];
            m_wdata = s_wdata[8*m_owner +: 8];
          end
        end else begin
          m_ph++;
          if (m_end == 0 && m_ph >= 3) begin
            if (s_fin) begin
              m_end = m_ph;
              if (!m_we) m_rdata = s_rdata;
            end else if (m_ph - 3 == TIMEOUT - 1) begin
              m_end = m_ph; m_err = 1; m_rdata = 8'hFF;
            end
          end else if (m_end != 0) begin
            m_owner = -1;
          end
        end
      end
      act = (m_owner >= 0);
      e_gnt  = (act && m_end == 0) ? 3'(1 << m_owner) : 3'b000;
      e_done = (act && m_end != 0) ? 3'(1 << m_owner) : 3'b000;
      exp_v = {e_gnt, e_done, m_rdata, act && m_end != 0 && m_err, act, act && m_ph == 2,
               (act && m_ph >= 2 && m_end == 0) ? m_we : 1'b0,
               (act && m_ph >= 2 && m_end == 0) ? m_addr : 8'h00,
               (act && m_ph >= 2 && m_end == 0) ? m_wdata : 8'h00};
      #1;
      act_v = {gnt_o, done_o, rdata_o, err_o, busy_o, bus_start, bus_we, bus_addr, bus_wdata};
      check("cycle_outputs {gnt,done,rdata,err,busy,start,we,addr,wdata}", 64'(act_v), 64'(exp_v));
      if (bus_start) begin st_cyc.push_back(cyc); st_addr.push_back(bus_addr); st_wdata.push_back(bus_wdata); end
      if (done_o != 3'b000) begin
        dn_cyc.push_back(cyc); dn_val.push_back(done_o); dn_rdata.push_back(rdata_o); dn_err.push_back(err_o);
      end
      if (gnt_o != 3'b000 && prev_gnt == 3'b000) begin gr_cyc.push_back(cyc); gr_val.push_back(gnt_o); end
      prev_gnt = gnt_o;
    end
  end

  task automatic wait_quiet(input int max_cyc, input string nm);
    int q;
    int k;
    q = 0; k = 0;
    while (q < 3 && k < max_cyc) begin
      @(negedge clk);
      k++;
      if (req_i == 3'b000 && busy_o == 1'b0 &&
          head[0] == tail[0] && head[1] == tail[1] && head[2] == tail[2]) q++;
      else q = 0;
    end
    if (q < 3) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: not idle after %0d cycles", nm, k);
    end
  endtask

  initial begin
    int bs, bd, bg, idx2, after2, lat, k;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_outputs", 64'({gnt_o, done_o, rdata_o, err_o, busy_o, bus_start, bus_addr}), 64'h0);

    // 1: single write from requester 1
    @(negedge clk);
    bs = st_cyc.size(); bd = dn_cyc.size(); bg = gr_cyc.size();
    eng_delay = 5;
    push(1, 1'b1, 8'h21, 8'h45, 1'b0);
    wait_quiet(200, "t1_quiet");
    check("t1_starts", st_cyc.size() - bs, 1);
    check("t1_addr", st_addr[bs], 8'h21);
    check("t1_wdata", st_wdata[bs], 8'h45);
    check("t1_gnt_val", gr_val[bg], 3'b010);
    check("t1_gnt_lat", gr_cyc[bg] - raise_cyc[1], 1);
    check("t1_dones", dn_cyc.size() - bd, 1);
    check("t1_done_val", dn_val[bd], 3'b010);
    check("t1_req_to_done", dn_cyc[bd] - raise_cyc[1], 8);
    check("t1_rdata_unchanged", rdata_o, 8'h00);

    // 2: simultaneous requests resolve 0,1,2
    @(negedge clk);
    bs = st_cyc.size(); bd = dn_cyc.size();
    eng_delay = 3; eng_rdata = 8'h33;
    push(0, 1'b0, 8'h10, 8'h00, 1'b0);
    push(1, 1'b1, 8'h11, 8'h99, 1'b0);
    push(2, 1'b0, 8'h12, 8'h00, 1'b0);
    wait_quiet(200, "t2_quiet");
    check("t2_starts", st_cyc.size() - bs, 3);
    check("t2_dones", dn_cyc.size() - bd, 3);
    check("t2_order", {dn_val[bd], dn_val[bd+1], dn_val[bd+2]}, 9'b001_010_100);
    check("t2_addrs", {st_addr[bs], st_addr[bs+1], st_addr[bs+2]}, 24'h101112);
    check("t2_rdata", rdata_o, 8'h33);

    // 3: requester 2 starved by busy 0/1 gets promoted by aging
    @(negedge clk);
    bd = dn_cyc.size();
    eng_delay = 2; eng_rdata = 8'h17;
    for (int i = 0; i < 20; i++) begin
      push(0, 1'b1, 8'h60 + 8'(i), 8'(i), 1'b0);
      push(1, 1'b1, 8'h80 + 8'(i), 8'(i), 1'b0);
    end
    push(2, 1'b0, 8'h23, 8'h00, 1'b0);
    wait_quiet(1000, "t3_quiet");
    idx2 = -1; after2 = 0;
    for (int i = bd; i < dn_cyc.size(); i++) begin
      if (idx2 >= 0) after2++;
      else if (dn_val[i] == 3'b100) idx2 = i;
    end
    check("t3_found", idx2 >= 0, 1);
    if (idx2 >= 0) begin
      lat = dn_cyc[idx2] - raise_cyc[2];
      check("t3_rdata", dn_rdata[idx2], 8'h17);
      check("t3_latency_min", lat >= MAX_WAIT, 1);
      check("t3_latency_max", lat <= MAX_WAIT + 16, 1);
      check("t3_not_last", after2 > 20, 1);
    end

    // 4: engine hangs -> timeout, then normal service
    @(negedge clk);
    bs = st_cyc.size(); bd = dn_cyc.size();
    eng_delay = 0;
    push(0, 1'b0, 8'h30, 8'h00, 1'b0);
    wait_quiet(TIMEOUT + 100, "t4_quiet");
    check("t4_dones", dn_cyc.size() - bd, 1);
    check("t4_err", dn_err[bd], 1);
    check("t4_done_val", dn_val[bd], 3'b001);
    check("t4_timeout_cycles", dn_cyc[bd] - st_cyc[bs], TIMEOUT);
    check("t4_rdata_ff", rdata_o, 8'hFF);
    bd = dn_cyc.size();
    eng_delay = 4; eng_rdata = 8'h42;
    push(1, 1'b0, 8'h31, 8'h00, 1'b0);
    wait_quiet(200, "t4b_quiet");
    check("t4b_err", dn_err[bd], 0);
    check("t4b_rdata", rdata_o, 8'h42);

    // 5: reset in WAIT aborts silently; spurious fin afterwards is ignored
    @(negedge clk);
    bs = st_cyc.size(); bd = dn_cyc.size();
    eng_delay = 0;
    push(2, 1'b1, 8'h40, 8'h12, 1'b0);
    k = 0;
    while (st_cyc.size() == bs && k < 20) begin @(negedge clk); k++; end
    check("t5_started", st_cyc.size() - bs, 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_reset_outputs",
          64'({gnt_o, done_o, err_o, busy_o, bus_start, bus_we, bus_addr, bus_wdata, rdata_o}), 64'h0);
    spur_req = spur_req + 1;
    repeat (6) @(negedge clk);
    check("t5_no_done", dn_cyc.size() - bd, 0);
    check("t5_idle", busy_o, 0);

    // 6: owner holds req one cycle past done -> IDLE re-grants; compliant release -> one grant
    @(negedge clk);
    bs = st_cyc.size(); bg = gr_cyc.size();
    eng_delay = 3;
    push(0, 1'b1, 8'h50, 8'h01, 1'b1);
    wait_quiet(200, "t6_quiet");
    check("t6_hold_starts", st_cyc.size() - bs, 2);
    check("t6_hold_grants", gr_cyc.size() - bg, 2);
    if (st_cyc.size() - bs == 2 && gr_cyc.size() - bg == 2)
      check("t6_start_after_gnt", st_cyc[bs+1] - gr_cyc[bg+1], 1);
    @(negedge clk);
    bs = st_cyc.size(); bg = gr_cyc.size(); bd = dn_cyc.size();
    push(0, 1'b1, 8'h51, 8'h02, 1'b0);
    wait_quiet(200, "t6b_quiet");
    check("t6b_starts", st_cyc.size() - bs, 1);
    check("t6b_grants", gr_cyc.size() - bg, 1);
    check("t6b_dones", dn_cyc.size() - bd, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
